fifo_to_axis_packer: RTL and testbench



---
 rtl/fifo_to_axis_packer_pkg.sv | 26 ++
 rtl/sync_fwft_fifo.sv | 60 ++++++
 rtl/fifo_to_axis_packer.sv | 175 +++++++++++++++++
 tb/tb_fifo_to_axis_packer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_to_axis_packer_pkg.sv
// Shared constants, state encoding and helpers for the FIFO-to-AXI-Stream packer.
package fifo_to_axis_packer_pkg;

    localparam int DEF_M_AXIS_DATA_WIDTH  = 256;
    localparam int DEF_M_AXIS_TUSER_WIDTH = 128;
    localparam int DEF_FIFO_DATA_WIDTH    = 64;
    localparam int DEF_FIFO_DEPTH         = 16;
    localparam int RATIO                  = DEF_M_AXIS_DATA_WIDTH / DEF_FIFO_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        DROP = 2'd2
    } pack_state_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is readable combinationally.
module sync_fwft_fifo
    import fifo_to_axis_packer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  set_tail_flag_i,
    input  logic                  rd_en_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic [log2(DEPTH):0]  count_o
);

    localparam int PTR_W = log2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W:0]   count_q;
    logic             do_wr;
    logic             do_rd;

    assign do_wr    = wr_en_i && (count_q != FULL_COUNT);
    assign do_rd    = rd_en_i && (count_q != '0);
    assign tail_ptr = wr_ptr_q - PTR_W'(1);

    // NOTE: the storage array is deliberately not reset; pointers and count gate what is visible.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
        // Flag bit 0 of the most recently written entry (used to close a truncated packet).
        if (set_tail_flag_i) mem_q[tail_ptr][0] <= 1'b1;
    end

    // NOTE: registers use <= so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/fifo_to_axis_packer.sv
// Packs narrow FIFO words into wide AXI-Stream beats, buffers them and emits them
// in cut-through or store-and-forward mode; overflowing packets are truncated.
module fifo_to_axis_packer
    import fifo_to_axis_packer_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = DEF_M_AXIS_DATA_WIDTH,
    parameter int C_M_AXIS_TUSER_WIDTH = DEF_M_AXIS_TUSER_WIDTH,
    parameter int FIFO_DATA_WIDTH      = DEF_FIFO_DATA_WIDTH,
    parameter int FIFO_DEPTH           = DEF_FIFO_DEPTH,
    parameter int C_STORE_FWD          = 0
) (
    input  logic                               axi_aclk,
    input  logic                               axi_rst,
    input  logic                               sw_rst,
    input  logic                               fifo_wr_en,
    input  logic [FIFO_DATA_WIDTH-1:0]         fifo_din,
    input  logic [FIFO_DATA_WIDTH/8-1:0]       fifo_din_strb,
    input  logic                               fifo_din_last,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0]    fifo_din_tuser,
    output logic                               fifo_full,
    output logic                               fifo_almost_full,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               m_axis_tlast,
    output logic [log2(FIFO_DEPTH):0]          pkt_count,
    output logic [31:0]                        drop_count
);

    localparam int DW     = C_M_AXIS_DATA_WIDTH;
    localparam int SW     = DW / 8;
    localparam int FW     = FIFO_DATA_WIDTH;
    localparam int FSW    = FW / 8;
    localparam int TW     = C_M_AXIS_TUSER_WIDTH;
    localparam int LANES  = DW / FW;
    localparam int LANE_W = (LANES > 1) ? log2(LANES) : 1;
    localparam int CNT_W  = log2(FIFO_DEPTH) + 1;
    localparam int BEAT_W = DW + SW + 1;
    localparam logic [LANE_W-1:0] LAST_LANE    = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  FULL_LEVEL   = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  ALMOST_LEVEL = CNT_W'(FIFO_DEPTH - 4);

    pack_state_e       state_q, state_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [DW-1:0]     acc_data_q, acc_data_d;
    logic [SW-1:0]     acc_strb_q, acc_strb_d;
    logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;
    logic [31:0]       drop_count_q, drop_count_d;
    logic              guard_q, guard_d;

    logic              rst;
    logic              beat_push, tuser_push, mark_tail, word_drop;
    logic [DW-1:0]     beat_data;
    logic [SW-1:0]     beat_strb;
    logic [BEAT_W-1:0] beat_head;
    logic [TW-1:0]     tuser_head;
    logic [CNT_W-1:0]  beat_count, tuser_count;
    logic              out_valid, out_pop, head_last, released;

    assign rst = axi_rst | sw_rst;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        acc_data_d = acc_data_q;
        acc_strb_d = acc_strb_q;
        beat_data  = acc_data_q;
        beat_strb  = acc_strb_q;
        beat_push  = 1'b0;
        tuser_push = 1'b0;
        mark_tail  = 1'b0;
        word_drop  = 1'b0;
        if (fifo_wr_en) begin
            if (fifo_full || state_q == DROP) begin
                word_drop = 1'b1;
                mark_tail = (state_q == PACK);
                state_d   = fifo_din_last ? IDLE : DROP;
            end else begin
                tuser_push = (state_q == IDLE);
                for (int i = 0; i < LANES; i++) begin
                    if (lane_q == LANE_W'(i)) begin
                        beat_data[i*FW +: FW]   = fifo_din;
                        beat_strb[i*FSW +: FSW] = fifo_din_strb;
                    end
                end
                if (fifo_din_last || lane_q == LAST_LANE) begin
                    beat_push  = 1'b1;
                    lane_d     = '0;
                    acc_data_d = '0;
                    acc_strb_d = '0;
                end else begin
                    lane_d     = lane_q + LANE_W'(1);
                    acc_data_d = beat_data;
                    acc_strb_d = beat_strb;
                end
                state_d = fifo_din_last ? IDLE : PACK;
            end
        end
    end

    assign fifo_full        = beat_count >= FULL_LEVEL;
    assign fifo_almost_full = beat_count >= ALMOST_LEVEL;

    // A full FIFO with no complete packet would stall store-and-forward forever.
    assign released  = guard_q || (fifo_full && pkt_count_q == '0);
    assign head_last = beat_head[0];
    assign out_valid = (beat_count != '0) && (tuser_count != '0) &&
                       ((C_STORE_FWD == 0) || (pkt_count_q != '0) || released);
    assign out_pop   = out_valid && m_axis_tready;

    always_comb begin
        pkt_count_d = pkt_count_q;
        case ({(beat_push && fifo_din_last) || mark_tail, out_pop && head_last})
            2'b10:   pkt_count_d = pkt_count_q + CNT_W'(1);
            2'b01:   pkt_count_d = pkt_count_q - CNT_W'(1);
            default: pkt_count_d = pkt_count_q;
        endcase
        drop_count_d = (word_drop && drop_count_q != '1) ? drop_count_q + 32'd1 : drop_count_q;
        guard_d      = released && !(out_pop && head_last);
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            acc_data_q   <= '0;
            acc_strb_q   <= '0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
            guard_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            acc_data_q   <= acc_data_d;
            acc_strb_q   <= acc_strb_d;
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
            guard_q      <= guard_d;
        end
    end

    sync_fwft_fifo #(.WIDTH(BEAT_W), .DEPTH(FIFO_DEPTH)) u_beat_fifo (
        .clk_i           (axi_aclk),
        .rst_i           (rst),
        .wr_en_i         (beat_push),
        .wr_data_i       ({beat_data, beat_strb, fifo_din_last}),
        .set_tail_flag_i (mark_tail),
        .rd_en_i         (out_pop),
        .rd_data_o       (beat_head),
        .count_o         (beat_count)
    );

    sync_fwft_fifo #(.WIDTH(TW), .DEPTH(FIFO_DEPTH)) u_tuser_fifo (
        .clk_i           (axi_aclk),
        .rst_i           (rst),
        .wr_en_i         (tuser_push),
        .wr_data_i       (fifo_din_tuser),
        .set_tail_flag_i (1'b0),
        .rd_en_i         (out_pop && head_last),
        .rd_data_o       (tuser_head),
        .count_o         (tuser_count)
    );

    assign m_axis_tvalid = out_valid;
    assign m_axis_tdata  = out_valid ? beat_head[BEAT_W-1 -: DW] : '0;
    assign m_axis_tstrb  = out_valid ? beat_head[SW:1] : '0;
    assign m_axis_tlast  = out_valid && head_last;
    assign m_axis_tuser  = out_valid ? tuser_head : '0;
    assign pkt_count     = pkt_count_q;
    assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_fifo_to_axis_packer.sv
// Directed bench with a queue-based reference model checked every cycle, plus literal spot checks.
module tb_fifo_to_axis_packer;
    import fifo_to_axis_packer_pkg::*;

    localparam int DW = 256, SW = 32, TW = 128, FW = 64, DEPTH = 16, LANES = RATIO;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          axi_rst = 1'b1, sw_rst = 1'b0, wr_en = 1'b0, din_last = 1'b0, tready = 1'b0;
    logic [FW-1:0] din = '0;
    logic [7:0]    strb = '0;
    logic [TW-1:0] tuser = '0;

    logic          ct_full, ct_afull, ct_valid, ct_last, sf_full, sf_afull, sf_valid, sf_last;
    logic [DW-1:0] ct_data, sf_data;
    logic [SW-1:0] ct_strb, sf_strb;
    logic [TW-1:0] ct_tuser, sf_tuser;
    logic [4:0]    ct_pkt, sf_pkt;
    logic [31:0]   ct_drop, sf_drop;

    fifo_to_axis_packer #(.C_STORE_FWD(0)) u_ct (
        .axi_aclk(clk), .axi_rst(axi_rst), .sw_rst(sw_rst), .fifo_wr_en(wr_en), .fifo_din(din),
        .fifo_din_strb(strb), .fifo_din_last(din_last), .fifo_din_tuser(tuser),
        .fifo_full(ct_full), .fifo_almost_full(ct_afull), .m_axis_tdata(ct_data),
        .m_axis_tstrb(ct_strb), .m_axis_tuser(ct_tuser), .m_axis_tvalid(ct_valid),
        .m_axis_tready(tready), .m_axis_tlast(ct_last), .pkt_count(ct_pkt), .drop_count(ct_drop));

    fifo_to_axis_packer #(.C_STORE_FWD(1)) u_sf (
        .axi_aclk(clk), .axi_rst(axi_rst), .sw_rst(sw_rst), .fifo_wr_en(wr_en), .fifo_din(din),
        .fifo_din_strb(strb), .fifo_din_last(din_last), .fifo_din_tuser(tuser),
        .fifo_full(sf_full), .fifo_almost_full(sf_afull), .m_axis_tdata(sf_data),
        .m_axis_tstrb(sf_strb), .m_axis_tuser(sf_tuser), .m_axis_tvalid(sf_valid),
        .m_axis_tready(tready), .m_axis_tlast(sf_last), .pkt_count(sf_pkt), .drop_count(sf_drop));

    // The model tracks whichever instance is selected; switching always goes through a reset.
    bit sel_sf = 1'b0, chk_en = 1'b0;
    wire          d_valid = sel_sf ? sf_valid : ct_valid;
    wire          d_last  = sel_sf ? sf_last  : ct_last;
    wire          d_full  = sel_sf ? sf_full  : ct_full;
    wire          d_afull = sel_sf ? sf_afull : ct_afull;
    wire [DW-1:0] d_data  = sel_sf ? sf_data  : ct_data;
    wire [SW-1:0] d_strb  = sel_sf ? sf_strb  : ct_strb;
    wire [TW-1:0] d_tuser = sel_sf ? sf_tuser : ct_tuser;
    wire [4:0]    d_pkt   = sel_sf ? sf_pkt   : ct_pkt;
    wire [31:0]   d_drop  = sel_sf ? sf_drop  : ct_drop;

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } beat_t;

    beat_t         mq[$];
    logic [TW-1:0] mtu[$];
    logic [FW-1:0] pend_d[$];
    logic [7:0]    pend_s[$];
    bit            m_in_pkt, m_dropping, m_guard;
    logic [31:0]   m_drops;

    function automatic int m_pkts();
        int n = 0;
        foreach (mq[i]) if (mq[i].last) n++;
        return n;
    endfunction

    function automatic bit m_valid();
        if (mq.size() == 0) return 1'b0;
        if (!sel_sf) return 1'b1;
        return (m_pkts() > 0) || m_guard || (mq.size() >= DEPTH - 1);
    endfunction

    task automatic model_step();
        bit    full_now, popped_last;
        int    pk;
        beat_t b;
        if (axi_rst || sw_rst) begin
            mq.delete(); mtu.delete(); pend_d.delete(); pend_s.delete();
            m_in_pkt = 0; m_dropping = 0; m_guard = 0; m_drops = '0;
            return;
        end
        full_now    = mq.size() >= DEPTH - 1;
        pk          = m_pkts();
        popped_last = 1'b0;
        if (m_valid() && tready) begin
            popped_last = mq[0].last;
            void'(mq.pop_front());
            if (popped_last) void'(mtu.pop_front());
        end
        m_guard = (m_guard || (sel_sf && full_now && pk == 0)) && !popped_last;
        if (wr_en) begin
            if (full_now || m_dropping) begin
                if (m_drops != 32'hFFFF_FFFF) m_drops++;
                if (m_in_pkt && mq.size() > 0) mq[mq.size()-1].last = 1'b1;
                m_in_pkt   = 1'b0;
                m_dropping = !din_last;
            end else begin
                if (!m_in_pkt) mtu.push_back(tuser);
                m_in_pkt = !din_last;
                pend_d.push_back(din);
                pend_s.push_back(strb);
                if (din_last || pend_d.size() == LANES) begin
                    b = '0;
                    foreach (pend_d[i]) begin
                        b.data[i*FW +: FW] = pend_d[i];
                        b.strb[i*8 +: 8]   = pend_s[i];
                    end
                    b.last = din_last;
                    mq.push_back(b);
                    pend_d.delete(); pend_s.delete();
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            bit v;
            v = m_valid();
            check("tvalid", d_valid, v);
            check("tlast", d_last, v ? mq[0].last : 1'b0);
            check("tdata", d_data, v ? mq[0].data : '0);
            check("tstrb", d_strb, v ? mq[0].strb : '0);
            check("tuser", d_tuser, v ? mtu[0] : '0);
            check("pkt_count", d_pkt, m_pkts());
            check("drop_count", d_drop, m_drops);
            check("fifo_full", d_full, mq.size() >= DEPTH - 1);
            check("fifo_almost_full", d_afull, mq.size() >= DEPTH - 4);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [FW-1:0] d, input logic [7:0] s, input logic l, input logic [TW-1:0] u);
        wr_en = 1'b1; din = d; strb = s; din_last = l; tuser = u;
        tick();
        wr_en = 1'b0; din_last = 1'b0;
    endtask

    task automatic drain(input int cycles);
        tready = 1'b1;
        repeat (cycles) tick();
        tready = 1'b0;
    endtask

    logic [TW-1:0] seen[$];

    initial begin
        tick(); tick();
        axi_rst = 1'b0;
        chk_en  = 1'b1;
        check("reset tvalid", d_valid, 1'b0);
        check("reset pkt_count", d_pkt, 5'd0);
        check("reset full", d_full, 1'b0);

        // 1: four full words, last on word 4
        put(64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b0, 128'h5);
        put(64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 1'b0, 128'h5);
        put(64'hCCCC_CCCC_CCCC_CCCC, 8'hFF, 1'b0, 128'h5);
        check("t1 no early tvalid", d_valid, 1'b0);
        put(64'hDDDD_DDDD_DDDD_DDDD, 8'hFF, 1'b1, 128'h5);
        check("t1 tvalid", d_valid, 1'b1);
        check("t1 tdata", d_data, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                   64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});
        check("t1 tstrb", d_strb, 32'hFFFF_FFFF);
        check("t1 tlast", d_last, 1'b1);
        check("t1 tuser", d_tuser, 128'h5);
        drain(2);

        // 2: three words, partial last word
        put(64'h1111_1111_1111_1111, 8'hFF, 1'b0, 128'h6);
        put(64'h2222_2222_2222_2222, 8'hFF, 1'b0, 128'h6);
        put(64'h3333_3333_3333_3333, 8'h0F, 1'b1, 128'h6);
        check("t2 tstrb", d_strb, 32'h000F_FFFF);
        check("t2 upper lane zero", d_data[255:192], 64'h0);
        check("t2 tlast", d_last, 1'b1);
        drain(2);

        // 5: back-to-back one-word packets, tready toggling
        for (int c = 0; c < 12; c++) begin
            wr_en = (c < 3); din = 64'(c + 1); strb = 8'hFF; din_last = (c < 3); tuser = 128'(c + 1);
            tready = (c % 2 == 0);
            if (d_valid && tready && d_last) seen.push_back(d_tuser);
            tick();
        end
        wr_en = 1'b0; din_last = 1'b0; tready = 1'b0;
        check("t5 count", 32'(seen.size()), 32'd3);
        for (int i = 0; i < 3; i++) check("t5 tuser order", (i < seen.size()) ? seen[i] : '0, 128'(i + 1));

        // 4: 100-word packet against a stalled sink overflows and is truncated
        for (int i = 0; i < 100; i++) begin
            put(64'(i), 8'hFF, i == 99, 128'h44);
            if (i == 58) check("t4 not full at 14 beats", d_full, 1'b0);
            if (i == 59) check("t4 full at 15 beats", d_full, 1'b1);
        end
        check("t4 drop_count", d_drop, 32'd40);
        check("t4 pkt_count", d_pkt, 5'd1);
        tready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            check("t4 truncated tlast", d_last, i == 14);
            tick();
        end
        tready = 1'b0;
        check("t4 drained", d_valid, 1'b0);
        put(64'h1, 8'hFF, 1'b0, 128'h45);
        put(64'h2, 8'hFF, 1'b1, 128'h46);
        check("t4 clean tstrb", d_strb, 32'h0000_FFFF);
        check("t4 clean tuser", d_tuser, 128'h45);
        drain(2);

        // 6: reset mid-packet with two beats buffered
        for (int i = 0; i < 9; i++) put(64'(i + 100), 8'hFF, 1'b0, 128'h70);
        axi_rst = 1'b1;
        tick();
        axi_rst = 1'b0;
        check("t6 tvalid after reset", d_valid, 1'b0);
        check("t6 pkt_count after reset", d_pkt, 5'd0);
        check("t6 drop_count after reset", d_drop, 32'd0);
        put(64'h0123_4567_89AB_CDEF, 8'h0F, 1'b1, 128'h77);
        check("t6 lane0 tstrb", d_strb, 32'h0000_000F);
        check("t6 lane0 tdata", d_data, 256'h0123_4567_89AB_CDEF);
        drain(2);

        // 3: store-and-forward, 9-word packet held until complete
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        sel_sf = 1'b1;
        for (int i = 0; i < 9; i++) begin
            put({8{8'(i + 1)}}, 8'hFF, i == 8, 128'h9);
            if (i < 8) check("t3 held", d_valid, 1'b0);
        end
        check("t3 tvalid", d_valid, 1'b1);
        check("t3 pkt_count one", d_pkt, 5'd1);
        check("t3 beat1 tstrb", d_strb, 32'hFFFF_FFFF);
        tready = 1'b1;
        tick();
        check("t3 beat2 tstrb", d_strb, 32'hFFFF_FFFF);
        tick();
        check("t3 beat3 tstrb", d_strb, 32'h0000_00FF);
        check("t3 beat3 tlast", d_last, 1'b1);
        tick();
        tready = 1'b0;
        check("t3 pkt_count zero", d_pkt, 5'd0);
        check("t3 empty", d_valid, 1'b0);
        tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
